// File: rtl/seq_divider.sv
// seq_divider: iterative 32-bit signed divider, restoring shift/subtract,
// one quotient bit per cycle. Divide-by-zero and the single signed overflow
// case (0x80000000 / -1) bypass the loop and finish two cycles after start.
module seq_divider (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic signed [31:0]  A,
  input  logic signed [31:0]  B,
  output logic                busy,
  output logic                done,
  output logic signed [31:0]  quotient,
  output logic signed [31:0]  remainder,
  output logic                div_by_zero,
  output logic                overflow
);

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIXUP, DONE} state_t;

  state_t                    state_q, state_d;
  logic [4:0]                count_q;

  // Operand and loop datapath; these carry no reset since every field is
  // rewritten before it is consumed.
  logic signed [DATA_W-1:0]  a_q, b_q;
  logic [DATA_W-1:0]         bmag_q;
  logic [DATA_W-1:0]         rem_q;
  logic [DATA_W-1:0]         q_q;

  logic [DATA_W:0]           shifted, trial;
  logic                      b_zero, ovf_case;

  // Magnitude of a two's-complement value; |0x80000000| stays 0x80000000.
  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] x);
    return x[DATA_W-1] ? DATA_W'(-x) : DATA_W'(x);
  endfunction

  // Conditional two's-complement negation, modulo 2^32.
  function automatic logic [DATA_W-1:0] negate_if(input logic [DATA_W-1:0] x,
                                                  input logic            neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  assign b_zero   = (b_q == '0);
  assign ovf_case = (a_q == {1'b1, {(DATA_W-1){1'b0}}}) && (b_q == '1);

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  // One restoring step: the partial remainder is always below |B| between
  // steps, so its 33rd bit is zero and only the low 32 bits are stored.
  always_comb begin
    shifted = {rem_q, q_q[DATA_W-1]};
    trial   = shifted - {1'b0, bmag_q};
  end

  // Next-state logic for the divide sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = PREP;
      PREP:    state_d = (b_zero || ovf_case) ? DONE : ITER;
      ITER:    if (count_q == 5'd31) state_d = FIXUP;
      FIXUP:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state, step counter and the registered result outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        PREP: begin
          count_q <= '0;
          if (b_zero) begin
            quotient    <= '1;
            remainder   <= a_q;
            div_by_zero <= 1'b1;
          end else if (ovf_case) begin
            quotient  <= {1'b1, {(DATA_W-1){1'b0}}};
            remainder <= '0;
            overflow  <= 1'b1;
          end
        end
        ITER: count_q <= count_q + 5'd1;
        FIXUP: begin
          quotient  <= negate_if(q_q, a_q[DATA_W-1] ^ b_q[DATA_W-1]);
          remainder <= negate_if(rem_q, a_q[DATA_W-1]);
        end
        default: ;
      endcase
    end
  end

  // Operand capture and the shift/subtract datapath.
  always_ff @(posedge clock) begin
    case (state_q)
      IDLE: begin
        if (start) begin
          a_q <= A;
          b_q <= B;
        end
      end
      PREP: begin
        rem_q  <= '0;
        q_q    <= magnitude(a_q);
        bmag_q <= magnitude(b_q);
      end
      ITER: begin
        rem_q <= trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
        q_q   <= {q_q[DATA_W-2:0], ~trial[DATA_W]};
      end
      default: ;
    endcase
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative 32-bit signed divider for the processor execute stage, the multi-cycle counterpart of the combinational add/subtract unit. It accepts a dividend and divisor on a start pulse and runs a restoring shift/subtract loop, one quotient bit per cycle. It returns quotient and remainder with a one-cycle done pulse. Divide-by-zero and the single signed-overflow case are flagged and take a fast path.

## Interface
Parameters:
- none. Width is fixed at 32 bits.

Ports:
- clock  input  1  rising-edge clock; the only clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- A  input  32  dividend, two's complement.
- B  input  32  divisor, two's complement.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; results are valid from this cycle onward.
- quotient  output  32  signed quotient, truncated toward zero.
- remainder  output  32  signed remainder; its sign follows the dividend.
- div_by_zero  output  1  set when B==0 for the last operation.
- overflow  output  1  set when A==0x80000000 and B==0xFFFFFFFF for the last operation.

## Operation
- States: IDLE, PREP, ITER, FIXUP, DONE.
- IDLE:
  - If start=1, latch A, B and their sign bits.
  - Clear div_by_zero and overflow.
  - Go to PREP.
  - quotient and remainder keep their previous values until the next result write.
- PREP, special cases, each goes to DONE:
  - B==0: quotient=0xFFFFFFFF, remainder=A, div_by_zero=1.
  - A==0x80000000 and B==0xFFFFFFFF: quotient=0x80000000, remainder=0, overflow=1.
- PREP, otherwise:
  - Form |A| and |B| as 32-bit unsigned. |0x80000000| = 0x80000000, which fits unsigned.
  - Clear the 33-bit partial remainder.
  - Load the quotient shift register with |A|.
  - count=0, go to ITER.
- ITER, one step per cycle:
  - Shift {rem, q} left by 1.
  - trial = rem − {1'b0,|B|} (33-bit).
  - If trial[32]==0: rem=trial and q[0]=1.
  - count increments; after the count==31 step, go to FIXUP.
- FIXUP:
  - quotient = q, negated if sign(A) != sign(B).
  - remainder = rem[31:0], negated if sign(A)=1.
  - Go to DONE.
- DONE: done=1 for exactly this cycle, then go to IDLE.
- Arithmetic rules:
  - All arithmetic is modulo 2^32 except the 33-bit trial subtract.
  - Invariant for non-special inputs: A == quotient*B + remainder and |remainder| < |B|.
- Boundary conditions:
  - start while busy=1, including during the DONE cycle, is ignored and not queued.
  - A and B changes after acceptance have no effect.
  - A==0 with B!=0 gives quotient=0, remainder=0 through the normal path.
  - Reset mid-operation aborts immediately. No done pulse is produced for the aborted operation.

## Timing
- Reset values: state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0.
- Timing reference: E0 is the rising edge at which start is sampled in IDLE.
- busy: rises after E0 and falls after the DONE cycle.
- Normal path:
  - PREP at E0+1.
  - ITER steps at edges E0+2 .. E0+33 (32 steps).
  - FIXUP at E0+34.
  - done=1 and results valid in the cycle after E0+34.
  - IDLE after E0+35.
- Special path:
  - Results and flag written at E0+1.
  - done=1 in the cycle after E0+1.
  - IDLE after E0+2.
- Earliest next accepted start: E0+36 (normal) or E0+3 (special).
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- 100/7: start with A=100, B=7 → done rises exactly 34 edges after E0; quotient=14, remainder=2, flags 0.
- −100/7 and 100/−7:
  - A=0xFFFFFF9C, B=7 → quotient=0xFFFFFFF2, remainder=0xFFFFFFFE.
  - A=100, B=0xFFFFFFF9 → quotient=0xFFFFFFF2, remainder=2.
- Special cases:
  - A=0x12345678, B=0 → done after E0+1; quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1.
  - A=0x80000000, B=0xFFFFFFFF → quotient=0x80000000, remainder=0, overflow=1.
- Extremes:
  - A=0x80000000, B=1 → quotient=0x80000000, remainder=0, flags 0.
  - A=7, B=0x80000000 → quotient=0, remainder=7.
- Back-to-back:
  - Pulse start again at E0+10 with new operands → ignored, and the first result is unchanged.
  - A start accepted at E0+36 produces a correct second result.
- Reset mid-ITER: deassert reset_n at E0+15 → all outputs 0, busy=0 with no done pulse; a following 100/7 returns 14/2.
- Random: 10k random A/B pairs checked against the invariant and a reference model with C-style truncation.
